// File: rtl/mtimer_ctrl.sv
// Machine-timer controller: split 64-bit mtime with registered carry, CSR-style access port, mtimecmp/mtip.
// Optional MTIMER_SNAPSHOT_EN: an mtime_lo read snapshots effective hi for a coherent following mtime_hi read.
module mtimer_ctrl #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        count_en,
    input  logic        en_rw,
    input  logic [1:0]  addr,
    input  logic [1:0]  rw_mode,
    input  logic [31:0] d,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        mtip
);

    localparam logic [1:0] ADDR_MTIME_LO = 2'd0;
    localparam logic [1:0] ADDR_MTIME_HI = 2'd1;
    localparam logic [1:0] ADDR_CMP_LO   = 2'd2;
    localparam logic [1:0] ADDR_CMP_HI   = 2'd3;

    localparam logic [1:0] MODE_READ  = 2'b00;
    localparam logic [1:0] MODE_WRITE = 2'b01;
    localparam logic [1:0] MODE_SET   = 2'b10;
    localparam logic [1:0] MODE_CLEAR = 2'b11;

    localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

    logic [15:0] presc_q;
    logic [31:0] lo_q;
    logic [31:0] hi_q;
    logic        carry_q;
    logic [31:0] cmp_lo_q;
    logic [31:0] cmp_hi_q;
    logic        cmp_hold_q;

    logic        tick;
    logic [31:0] eff_hi;
    logic [31:0] old_val;
    logic [31:0] rd_val;
    logic [31:0] new_val;
    logic        wr;
    logic        wr_lo;
    logic        wr_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;
    logic        rd_lo;
    logic        rd_hi;
    logic [31:0] lo_next;
    logic [31:0] hi_next;
    logic        carry_next;
    logic        mtip_next;

    assign tick   = count_en && (presc_q == PRESC_MAX);
    // A carry still sitting in carry_q belongs to hi already, so every observer adds it in.
    assign eff_hi = hi_q + {31'd0, carry_q};

    assign wr        = en_rw && (rw_mode != MODE_READ);
    assign wr_lo     = wr && (addr == ADDR_MTIME_LO);
    assign wr_hi     = wr && (addr == ADDR_MTIME_HI);
    assign wr_cmp_lo = wr && (addr == ADDR_CMP_LO);
    assign wr_cmp_hi = wr && (addr == ADDR_CMP_HI);
    assign rd_lo     = en_rw && (rw_mode == MODE_READ) && (addr == ADDR_MTIME_LO);
    assign rd_hi     = en_rw && (rw_mode == MODE_READ) && (addr == ADDR_MTIME_HI);

    always_comb begin
        old_val = 32'd0;
        unique case (addr)
            ADDR_MTIME_LO: old_val = lo_q;
            ADDR_MTIME_HI: old_val = eff_hi;
            ADDR_CMP_LO:   old_val = cmp_lo_q;
            ADDR_CMP_HI:   old_val = cmp_hi_q;
            default:       old_val = 32'd0;
        endcase
    end

    always_comb begin
        new_val = old_val;
        unique case (rw_mode)
            MODE_READ:  new_val = old_val;
            MODE_WRITE: new_val = d;
            MODE_SET:   new_val = old_val | d;
            MODE_CLEAR: new_val = old_val & ~d;
            default:    new_val = old_val;
        endcase
    end

    // A write to either half wins over the counter for that half; a hi write also swallows any carry.
    always_comb begin
        lo_next    = lo_q;
        hi_next    = eff_hi;
        carry_next = 1'b0;
        if (wr_lo) begin
            lo_next = new_val;
        end else if (tick) begin
            lo_next    = lo_q + 32'd1;
            carry_next = (lo_q == 32'hFFFF_FFFF);
        end
        if (wr_hi) begin
            hi_next    = new_val;
            carry_next = 1'b0;
        end
    end

    assign mtip_next = !cmp_hold_q && ({eff_hi, lo_q} >= {cmp_hi_q, cmp_lo_q});

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            presc_q <= 16'd0;
        end else if (count_en) begin
            presc_q <= tick ? 16'd0 : presc_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            lo_q    <= 32'd0;
            hi_q    <= 32'd0;
            carry_q <= 1'b0;
        end else begin
            lo_q    <= lo_next;
            hi_q    <= hi_next;
            carry_q <= carry_next;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cmp_lo_q   <= 32'hFFFF_FFFF;
            cmp_hi_q   <= 32'hFFFF_FFFF;
            cmp_hold_q <= 1'b0;
        end else begin
            if (wr_cmp_lo) begin
                cmp_lo_q   <= new_val;
                cmp_hold_q <= 1'b1;
            end
            if (wr_cmp_hi) begin
                cmp_hi_q   <= new_val;
                cmp_hold_q <= 1'b0;
            end
        end
    end

`ifdef MTIMER_SNAPSHOT_EN
    logic [31:0] snap_hi_q;
    logic        snap_valid_q;

    assign rd_val = (rd_hi && snap_valid_q) ? snap_hi_q : old_val;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            snap_hi_q    <= 32'd0;
            snap_valid_q <= 1'b0;
        end else if (rd_lo) begin
            snap_hi_q    <= eff_hi;
            snap_valid_q <= 1'b1;
        end else if (wr_lo || wr_hi || rd_hi) begin
            snap_valid_q <= 1'b0;
        end
    end
`else
    logic unused_rd;
    assign unused_rd = rd_lo ^ rd_hi;
    assign rd_val    = old_val;
`endif

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata  <= 32'd0;
            rvalid <= 1'b0;
            mtip   <= 1'b0;
        end else begin
            rvalid <= en_rw;
            mtip   <= mtip_next;
            if (en_rw) begin
                rdata <= rd_val;
            end
        end
    end

endmodule

// File: doc/mtimer_ctrl.md
# mtimer_ctrl

Machine-timer controller that sequences the split 64-bit time counter (low and high 32-bit halves with a registered carry between them), arbitrates CSR-style accesses against free-running increments, and compares against a 64-bit mtimecmp to raise the machine timer interrupt. It sits beside the CSR file: the CSR decoder drives its access port, and mtip feeds the interrupt controller.

## Interface
- PRESCALE, 1: clk cycles per time increment while counting (1..65535).
- clk  in  1  system clock.
- nreset  in  1  asynchronous, active-low reset.
- count_en  in  1  counter enable; low freezes the prescaler and the counter.
- en_rw  in  1  access strobe, one access per asserted cycle.
- addr  in  2  0 = mtime_lo, 1 = mtime_hi, 2 = mtimecmp_lo, 3 = mtimecmp_hi.
- rw_mode  in  2  00 read only, 01 write (CSRRW), 10 set bits (CSRRS), 11 clear bits (CSRRC).
- d  in  32  write / mask data.
- rdata  out  32  registered read data: the old value of the addressed register.
- rvalid  out  1  one-cycle pulse, cycle after en_rw.
- mtip  out  1  registered timer interrupt, level.

## Operation
- Tick: the prescaler counts 0..PRESCALE-1 while count_en is high; tick is asserted when it wraps. PRESCALE = 1 ticks every enabled cycle.
- Low half: on tick, lo <= lo+1. If lo was 32'hFFFF_FFFF, set carry_pend.
- High half: when carry_pend is set, hi <= hi+1 on the next edge and carry_pend clears. The carry is applied regardless of count_en.
- Effective time: {hi + carry_pend, lo}. All reads and compares use effective time, never the raw hi.
- Access read value: for addr 0/1, the effective half; for addr 2/3, the mtimecmp half.
- Access write value, applied to the addressed register:
  - 01: d.
  - 10: old | d.
  - 11: old & ~d.
  - 00: no write.
- Write vs tick on the same edge: the write wins for the written half.
  - Write to lo: the tick is discarded and no carry is generated.
  - Write to hi: any pending carry is discarded, and a carry produced by lo on that same edge is also discarded.
- Compare guard: any write to mtimecmp_lo sets cmp_hold. A write to mtimecmp_hi clears it. While cmp_hold is set, mtip is forced 0. This makes the software lo-then-hi update sequence glitch-free.
- Interrupt: mtip <= !cmp_hold && (effective time >= {cmp_hi, cmp_lo}), evaluated every cycle as an unsigned 64-bit compare.
- Reset values: lo = 0, hi = 0, carry_pend = 0, prescaler = 0, mtimecmp = 64'hFFFF_FFFF_FFFF_FFFF, cmp_hold = 0, rdata = 0, rvalid = 0, mtip = 0.
- Reset mid-operation: all state returns to the reset values immediately (asynchronous). A pending carry is lost.

## Timing
- Access latency: rdata/rvalid are valid on the edge after the en_rw cycle. rdata is the pre-write value, sampled in the en_rw cycle.
- Back-to-back accesses are accepted every cycle; rvalid follows each access with 1 cycle latency.
- Write visibility: a write updates the register at the edge closing the en_rw cycle. A read of the same address in the next cycle returns the new value.
- Carry ripple: lo wraps at edge N and hi increments at edge N+1. Effective hi already reads the incremented value in cycle N+1 because of the carry_pend correction.
- mtip: asserts one edge after effective time first satisfies the compare. It deasserts one edge after the condition fails or cmp_hold sets.

## Configuration
- MTIMER_SNAPSHOT_EN defined:
  - A read of mtime_lo latches effective hi (as of that same cycle) into a shadow register and sets snap_valid.
  - A later mtime_hi read returns the shadow and clears snap_valid.
  - Any write to mtime_lo or mtime_hi also clears snap_valid.
  - The result is a coherent lo-then-hi 64-bit read across a wrap.
- MTIMER_SNAPSHOT_EN undefined: mtime_hi reads always return live effective hi. No shadow register or snap_valid exists.

## Test plan
- Reset, then 3 cycles with count_en = 1 and PRESCALE = 1, then read addr 0 -> rdata = 3, rvalid high exactly one cycle; mtip = 0.
- Write lo = 32'hFFFF_FFFE, count 2 ticks -> lo = 0, hi = 1 the next edge; a hi read in the carry_pend cycle returns 1.
- Write mtimecmp_lo = 10 -> mtip held 0 even though time ≥ {all-ones hi, 10} is false. Then write mtimecmp_hi = 0 and let time reach 10 -> mtip rises 1 cycle later.
- Write lo with rw_mode 01 in the same cycle a tick and a wrap would occur -> lo = d, hi unchanged, carry_pend = 0. Then rw_mode 10 with d = 32'h0F on lo = 32'h30 -> rdata = 32'h30, lo = 32'h3F.
- With MTIMER_SNAPSHOT_EN and lo = 32'hFFFF_FFFF, hi = 5: read lo, tick, read hi -> returns 5. Without the macro the same sequence returns 6.
- Assert nreset while carry_pend = 1 -> all outputs 0 asynchronously, mtimecmp = all ones, no hi increment after release.
